// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense path: drink codes, dispenser
// state encoding and default stage durations.
package vend_pkg;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_PLAIN = 3'd1;
  localparam logic [2:0] SEL_HAZEL = 3'd2;
  localparam logic [2:0] SEL_COCO  = 3'd3;

  typedef enum logic [2:0] {
    DISP_IDLE   = 3'd0,
    DISP_CUP    = 3'd1,
    DISP_WATER  = 3'd2,
    DISP_FLAVOR = 3'd3,
    DISP_DONE   = 3'd4,
    DISP_REJECT = 3'd5
  } disp_state_e;

  localparam int unsigned DEF_CUP_CYCLES    = 4;
  localparam int unsigned DEF_WATER_CYCLES  = 16;
  localparam int unsigned DEF_FLAVOR_CYCLES = 8;
  localparam int unsigned DEF_COUNT_W       = 8;

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel == SEL_PLAIN) || (sel == SEL_HAZEL) || (sel == SEL_COCO);
  endfunction

endpackage

// File: rtl/coffee_dispenser_if.sv
// Four-phase dispense handshake between the vend controller (master) and the
// dispenser (slave).
interface coffee_dispenser_if;
  logic       dispense;
  logic [2:0] coffee_select;
  logic       dispense_done;
  logic       error;

  modport master (output dispense, coffee_select, input dispense_done, error);
  modport slave  (input dispense, coffee_select, output dispense_done, error);
endinterface

// File: rtl/coffee_dispenser_stage_timer.sv
// Shared stage down-counter: loads a duration, counts to zero and holds there.
module stage_timer #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  output logic [COUNT_W-1:0] value,
  output logic               expired
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/coffee_dispenser.sv
// Dispenser-side responder: timed cup/water/flavour sequence with a four-phase
// done handshake. Define DISPENSE_STATS_EN to add the cups_served counter.
module coffee_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CUP_CYCLES    = DEF_CUP_CYCLES,
  parameter int unsigned WATER_CYCLES  = DEF_WATER_CYCLES,
  parameter int unsigned FLAVOR_CYCLES = DEF_FLAVOR_CYCLES,
  parameter int unsigned COUNT_W       = DEF_COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  coffee_dispenser_if.slave   disp,
  output logic                cup_drop,
  output logic                water_valve,
  output logic [1:0]          flavor_valve,
  output logic                busy
`ifdef DISPENSE_STATS_EN
  ,
  output logic [15:0]         cups_served
`endif
);

  localparam logic [2:0] ST_IDLE   = DISP_IDLE;
  localparam logic [2:0] ST_CUP    = DISP_CUP;
  localparam logic [2:0] ST_WATER  = DISP_WATER;
  localparam logic [2:0] ST_FLAVOR = DISP_FLAVOR;
  localparam logic [2:0] ST_DONE   = DISP_DONE;
  localparam logic [2:0] ST_REJECT = DISP_REJECT;

  localparam logic [COUNT_W-1:0] CUP_LOAD    = COUNT_W'(CUP_CYCLES - 1);
  localparam logic [COUNT_W-1:0] WATER_LOAD  = COUNT_W'(WATER_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FLAVOR_LOAD = COUNT_W'(FLAVOR_CYCLES - 1);

  logic [2:0]         state, state_d;
  logic [2:0]         sel_q;
  logic               latch_sel;
  logic               timer_load;
  logic [COUNT_W-1:0] timer_load_value;
  logic [COUNT_W-1:0] timer_value;
  logic               timer_expired;

  stage_timer #(.COUNT_W(COUNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

  // Only the expiry flag steers sequencing; the raw count is not needed here.
  logic unused_timer_value;
  assign unused_timer_value = ^timer_value;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d          = state;
    latch_sel        = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;
    case (state)
      ST_IDLE: begin
        if (disp.dispense) begin
          if (sel_valid(disp.coffee_select)) begin
            state_d          = ST_CUP;
            latch_sel        = 1'b1;
            timer_load       = 1'b1;
            timer_load_value = CUP_LOAD;
          end else begin
            state_d = ST_REJECT;
          end
        end
      end
      ST_CUP: begin
        if (!disp.dispense) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d          = ST_WATER;
          timer_load       = 1'b1;
          timer_load_value = WATER_LOAD;
        end
      end
      ST_WATER: begin
        if (!disp.dispense) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          if (sel_q == SEL_PLAIN) begin
            state_d = ST_DONE;
          end else begin
            state_d          = ST_FLAVOR;
            timer_load       = 1'b1;
            timer_load_value = FLAVOR_LOAD;
          end
        end
      end
      ST_FLAVOR: begin
        if (!disp.dispense) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_REJECT: begin
        if (!disp.dispense) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, so each stage shows
  // on the pins one cycle after the state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      sel_q              <= SEL_NONE;
      cup_drop           <= 1'b0;
      water_valve        <= 1'b0;
      flavor_valve       <= 2'b00;
      busy               <= 1'b0;
      disp.dispense_done <= 1'b0;
      disp.error         <= 1'b0;
    end else begin
      state <= state_d;
      if (latch_sel) sel_q <= disp.coffee_select;
      cup_drop           <= (state == ST_CUP);
      water_valve        <= (state == ST_WATER);
      flavor_valve       <= (state != ST_FLAVOR) ? 2'b00 :
                            (sel_q == SEL_HAZEL) ? 2'b01 : 2'b10;
      busy               <= (state != ST_IDLE);
      disp.dispense_done <= (state == ST_DONE) || (state == ST_REJECT);
      disp.error         <= (state == ST_REJECT);
    end
  end

`ifdef DISPENSE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cups_served <= '0;
    end else if (state_d == ST_DONE && state != ST_DONE && cups_served != 16'hFFFF) begin
      cups_served <= cups_served + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coffee_dispenser.sv
// Scoreboard bench for coffee_dispenser: stimulus pushes timed output events,
// a monitor pops one per observed output change and compares time and value.
module tb_coffee_dispenser;
  import vend_pkg::*;

  typedef struct {
    int         t;
    logic [6:0] v;
  } ev_t;

  // Output vector: {busy, done, error, cup, water, flavor[1:0]}
  localparam logic [6:0] O_IDLE  = 7'b000_0000;
  localparam logic [6:0] O_CUP   = 7'b100_1000;
  localparam logic [6:0] O_WATER = 7'b100_0100;
  localparam logic [6:0] O_HAZ   = 7'b100_0001;
  localparam logic [6:0] O_COCO  = 7'b100_0010;
  localparam logic [6:0] O_DONE  = 7'b110_0000;
  localparam logic [6:0] O_REJ   = 7'b111_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cup_drop, water_valve, busy;
  logic [1:0] flavor_valve;
`ifdef DISPENSE_STATS_EN
  logic [15:0] cups_served;
`endif

  coffee_dispenser_if dif ();

  coffee_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .disp         (dif),
    .cup_drop     (cup_drop),
    .water_valve  (water_valve),
    .flavor_valve (flavor_valve),
    .busy         (busy)
`ifdef DISPENSE_STATS_EN
    ,
    .cups_served  (cups_served)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {busy, dif.dispense_done, dif.error, cup_drop, water_valve, flavor_valve};
  endfunction

  task automatic push(input int t, input logic [6:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    exp_q.push_back(e);
  endtask

  // Return at the negedge just before edge e so the inputs are sampled there.
  task automatic at_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic drive(input int e, input logic d, input logic [2:0] sel);
    at_edge(e);
    dif.dispense      = d;
    dif.coffee_select = sel;
  endtask

  // Monitor: every change of the output vector is one DUT event.
  initial begin
    logic [6:0] prev, cur;
    ev_t        e;
    prev = O_IDLE;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = out_vec();
      if (cur != prev) begin
        check("one_actuator", int'($countones(cur[3:0]) <= 1), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_event_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_time", cyc, e.t);
          check("event_value", int'(cur), int'(e.v));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         t, t2;
    logic [2:0] bad_sel [4];
    bad_sel = '{3'd0, 3'd4, 3'd5, 3'd7};

    dif.dispense      = 1'b0;
    dif.coffee_select = SEL_NONE;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'(out_vec()), int'(O_IDLE));
`ifdef DISPENSE_STATS_EN
    check("reset_cups_served", int'(cups_served), 0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;

    // Plain drink, released one cycle after done.
    t = cyc + 2;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 21, O_DONE); push(t + 23, O_IDLE);
    drive(t, 1'b1, SEL_PLAIN);
    drive(t + 22, 1'b0, SEL_PLAIN);

    // Coconut, with a select change mid-brew that must be ignored.
    t = cyc + 4;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 21, O_COCO);
    push(t + 29, O_DONE); push(t + 31, O_IDLE);
    drive(t, 1'b1, SEL_COCO);
    drive(t + 3, 1'b1, SEL_PLAIN);
    drive(t + 30, 1'b0, SEL_PLAIN);

    // Plain held 10 cycles past done, then hazelnut on the first legal edge.
    t  = cyc + 4;
    t2 = t + 32;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 21, O_DONE); push(t + 32, O_IDLE);
    push(t2 + 1, O_CUP); push(t2 + 5, O_WATER); push(t2 + 21, O_HAZ);
    push(t2 + 29, O_DONE); push(t2 + 31, O_IDLE);
    drive(t, 1'b1, SEL_PLAIN);
    drive(t + 31, 1'b0, SEL_PLAIN);
    drive(t2, 1'b1, SEL_HAZEL);
    drive(t2 + 30, 1'b0, SEL_HAZEL);

    // Abort during water: dispense sampled low at cycle 10.
    t = cyc + 4;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 11, O_IDLE);
    drive(t, 1'b1, SEL_PLAIN);
    drive(t + 10, 1'b0, SEL_PLAIN);

    // Invalid selects are rejected with done+error at cycle 1.
    for (int i = 0; i < 4; i++) begin
      t = cyc + 3;
      push(t + 1, O_REJ); push(t + 4, O_IDLE);
      drive(t, 1'b1, bad_sel[i]);
      drive(t + 3, 1'b0, bad_sel[i]);
    end

`ifdef DISPENSE_STATS_EN
    at_edge(cyc + 3);
    check("cups_served_before_reset", int'(cups_served), 4);
`endif

    // Reset sampled at cycle 15 of a hazelnut brew, request still held.
    t = cyc + 4;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 15, O_IDLE);
    drive(t, 1'b1, SEL_HAZEL);
    at_edge(t + 15);
    reset = 1'b1;
    at_edge(t + 16);
    reset = 1'b0;
    dif.dispense = 1'b0;

    // Plain drink after reset.
    t = cyc + 4;
    push(t + 1, O_CUP); push(t + 5, O_WATER); push(t + 21, O_DONE); push(t + 23, O_IDLE);
    drive(t, 1'b1, SEL_PLAIN);
    drive(t + 22, 1'b0, SEL_PLAIN);

    at_edge(t + 28);
    check("events_outstanding", exp_q.size(), 0);
`ifdef DISPENSE_STATS_EN
    check("cups_served_after_reset", int'(cups_served), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coffee_dispenser.md
# coffee_dispenser

Dispenser-side responder for the vending controller's dispense handshake. It accepts `dispense` and `coffee_select` from the vend controller and runs a timed cup/water/flavour sequence on the valve outputs. It then returns `dispense_done` under a four-phase handshake that survives the controller ignoring `done` while a button is held. It sits between the vend controller and the physical actuator drivers.

## Interface
- `CUP_CYCLES`, default 4: cycles `cup_drop` is held high.
- `WATER_CYCLES`, default 16: cycles `water_valve` is held high.
- `FLAVOR_CYCLES`, default 8: cycles the flavour valve is held high (hazelnut and coconut only).
- `COUNT_W`, default 8: width of the stage timer; all `*_CYCLES` values are 1..2^COUNT_W−1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dispense`  in  1  request level from the controller; held until `dispense_done` is seen.
- `coffee_select`  in  3  drink code: 1 plain, 2 hazelnut, 3 coconut, all others invalid.
- `dispense_done`  out  1  completion level, held until `dispense` is sampled low.
- `cup_drop`  out  1  cup release actuator.
- `water_valve`  out  1  hot water valve.
- `flavor_valve`  out  2  bit0 hazelnut, bit1 coconut.
- `busy`  out  1  a request is in progress (CUP, WATER, FLAVOR, DONE, REJECT).
- `error`  out  1  invalid select rejected; valid only while `dispense_done` is high.

## Operation
- States: IDLE, CUP, WATER, FLAVOR, DONE, REJECT. All outputs are registered.
- IDLE:
  - If `dispense`=1 and select is 1..3: latch the select and go to CUP.
  - If `dispense`=1 and select is 0 or 4..7: go to REJECT.
  - If `dispense`=0: stay in IDLE.
- CUP: `cup_drop`=1 for `CUP_CYCLES`, then go to WATER.
- WATER: `water_valve`=1 for `WATER_CYCLES`.
  - Latched select 1: go to DONE.
  - Latched select 2 or 3: go to FLAVOR.
- FLAVOR: `flavor_valve` = 2'b01 for hazelnut or 2'b10 for coconut, for `FLAVOR_CYCLES`, then go to DONE.
- DONE: `dispense_done`=1 and all actuators 0. Stays in DONE until `dispense` is sampled 0, then goes to IDLE with `dispense_done`=0 on the next cycle.
- REJECT: `dispense_done`=1 and `error`=1. Releases like DONE; `error` clears together with `dispense_done`.
- Abort: if `dispense` is sampled 0 in CUP, WATER or FLAVOR, all actuators go to 0 next cycle and the state returns to IDLE. No `dispense_done` is raised.
- Changes to `coffee_select` after the request is latched are ignored.
- The stage timer is loaded with `*_CYCLES`−1 on stage entry and the stage advances when it reads 0. The timer never wraps.
- Reset, including mid-brew, forces IDLE next cycle:
  - `dispense_done`, `cup_drop`, `water_valve`, `flavor_valve`, `busy`, `error` all 0.
  - Latched select and stage timer cleared.

## Timing
- Cycle 0 is the edge where IDLE samples a valid `dispense`=1.
- Plain: `cup_drop` high cycles 1..C, `water_valve` C+1..C+W, `dispense_done` rises at cycle C+W+1. With defaults this is cycle 21.
- Flavoured: flavour valve high C+W+1..C+W+F, `dispense_done` rises at cycle C+W+F+1. With defaults this is cycle 29.
- Reject: `dispense_done` and `error` rise at cycle 1.
- Release: `dispense` sampled 0 at cycle k drops `dispense_done` at cycle k+1.
- A new request is accepted no earlier than cycle k+1 sampling.
- At most one actuator output is high in any cycle.

## Configuration
- `DISPENSE_STATS_EN` defined: adds output `cups_served[15:0]` (reset 0).
  - Increments by 1 on each DONE entry and saturates at 16'hFFFF.
  - Aborts and rejects are not counted.
- Not defined: no port and no counter logic.

## Structure
- Package `vend_pkg` holds:
  - Drink codes `SEL_NONE`=0, `SEL_PLAIN`=1, `SEL_HAZEL`=2, `SEL_COCO`=3.
  - The dispenser state enum.
  - Default cycle constants.
- One sub-module, `stage_timer`: a `COUNT_W` down-counter with load, value and `expired` output, instantiated once and shared across stages.

## Test plan
- Plain: select=1, `dispense` held until done → `cup_drop` cycles 1–4, `water_valve` 5–20, no flavour, `dispense_done` at 21; drop `dispense` at 22 → `dispense_done`=0 at 23.
- Coconut: select=3 → `flavor_valve`=2'b10 for cycles 21–28, `dispense_done` at 29.
- Held request: `dispense` kept high 10 cycles after done → `dispense_done` stays 1 with no retrigger; release → done falls in 1 cycle, then a new request restarts at CUP.
- Abort: `dispense` dropped at cycle 10 → `water_valve` 0 at 11, state IDLE, `dispense_done` never asserts.
- Reject: select=0 or 5 → `dispense_done`=1 and `error`=1 at cycle 1, no actuator activity.
- Reset at cycle 15 of hazelnut → all outputs 0 next cycle; with `DISPENSE_STATS_EN`, `cups_served` unchanged by the aborted drink and incremented by completed drinks only.
